// File: rtl/matrix3x3_ctrl.sv
// rtl/matrix3x3_ctrl.sv - frame/line sequencer and window-validity flags for a 3x3 window generator
//
// Purpose:
//    Runs beside the 3x3 window generator on the same per_frame_* stream.
//    Tracks pixel column and line, and marks which 2-cycle-delayed window outputs
//    lie fully inside the image. Reports the window-centre coordinates and
//    checks frame geometry (pixels per line, lines per frame).
//
// Ports:
//    clk                 in   pixel clock
//    rst_n               in   asynchronous active-low reset
//    per_frame_vsync_i   in   frame valid, high during frame
//    per_frame_href_i    in   line valid
//    per_frame_clken_i   in   pixel strobe, meaningful only while href is high
//    err_clr_i           in   synchronous clear of the sticky error flags
//    win_valid_o         out  window at the matrix output is complete and inside the image
//    win_col_o           out  centre column of that window (0-based), held when not valid
//    win_row_o           out  centre row of that window (0-based), held when not valid
//    frame_start_o       out  1-cycle pulse, first cycle of an accepted frame
//    frame_done_o        out  1-cycle pulse at the end of an accepted frame
//    line_err_o          out  sticky: a line did not carry IMG_HDISP pixels
//    frame_err_o         out  sticky: a frame did not carry IMG_VDISP lines
//    busy_o              out  sequencer is inside a frame
module matrix3x3_ctrl #(
   parameter int IMG_HDISP = 320,
   parameter int IMG_VDISP = 240,
   parameter int CW        = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          per_frame_vsync_i,
   input  logic          per_frame_href_i,
   input  logic          per_frame_clken_i,
   input  logic          err_clr_i,
   output logic          win_valid_o,
   output logic [CW-1:0] win_col_o,
   output logic [CW-1:0] win_row_o,
   output logic          frame_start_o,
   output logic          frame_done_o,
   output logic          line_err_o,
   output logic          frame_err_o,
   output logic          busy_o
);

   localparam logic [CW-1:0] HD   = CW'(IMG_HDISP);
   localparam logic [CW-1:0] VD   = CW'(IMG_VDISP);
   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] TWO  = CW'(2);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LINE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          vsync_q, href_q;
   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;

   // window pipeline: stage 1 and stage 2 (outputs)
   logic          v1_q;
   logic [CW-1:0] col1_q, row1_q;
   logic          win_valid_q;
   logic [CW-1:0] win_col_q, win_row_q;

   logic          frame_start_q, frame_start_d;
   logic          frame_done_q, frame_done_d;
   logic          line_err_q, line_err_d;
   logic          frame_err_q, frame_err_d;
   logic          busy_q, busy_d;

   logic          vsync_rise, href_rise;
   logic          accept, line_end, win_hit;

   assign vsync_rise = per_frame_vsync_i & ~vsync_q;
   assign href_rise  = per_frame_href_i & ~href_q;

   // state register and all registered datapath/outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         // vsync history resets high so that a vsync already asserted at reset
         // release is not mistaken for a rising edge (no partial frames)
         vsync_q       <= 1'b1;
         href_q        <= 1'b0;
         col_q         <= '0;
         row_q         <= '0;
         v1_q          <= 1'b0;
         col1_q        <= '0;
         row1_q        <= '0;
         win_valid_q   <= 1'b0;
         win_col_q     <= '0;
         win_row_q     <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         line_err_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         vsync_q       <= per_frame_vsync_i;
         href_q        <= per_frame_href_i;
         col_q         <= col_d;
         row_q         <= row_d;
         v1_q          <= win_hit;
         if (win_hit) begin
            col1_q <= col_q - ONE;
            row1_q <= row_q - ONE;
         end
         win_valid_q   <= v1_q;
         if (v1_q) begin
            win_col_q <= col1_q;
            win_row_q <= row1_q;
         end
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         line_err_q    <= line_err_d;
         frame_err_q   <= frame_err_d;
         busy_q        <= busy_d;
      end
   end

   // next-state logic; losing vsync always closes the frame, even mid-line
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (vsync_rise) state_d = S_WAIT;
         S_WAIT: begin
            if (!per_frame_vsync_i)    state_d = S_DONE;
            else if (href_rise)        state_d = S_LINE;
         end
         S_LINE: begin
            if (!per_frame_vsync_i)    state_d = S_DONE;
            else if (!per_frame_href_i) state_d = S_WAIT;
         end
         S_DONE: state_d = vsync_rise ? S_WAIT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // counters, window flag and next values of the registered outputs
   always_comb begin
      accept        = 1'b0;
      line_end      = 1'b0;
      win_hit       = 1'b0;
      col_d         = '0;
      row_d         = row_q;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      line_err_d    = 1'b0;
      frame_err_d   = 1'b0;
      busy_d        = 1'b0;

      // A pixel counts whenever the line is (or is becoming) active; this
      // includes the strobe on the very cycle href rises. col_q is 0 outside
      // LINE, so it is the pixel's column in both cases.
      accept   = per_frame_clken_i & (state_d == S_LINE);
      line_end = (state_q == S_LINE) & (state_d != S_LINE);

      if (accept)
         col_d = (col_q == CMAX) ? col_q : col_q + ONE;
      else if (state_d == S_LINE)
         col_d = col_q;

      frame_start_d = vsync_rise & ((state_q == S_IDLE) | (state_q == S_DONE));
      if (frame_start_d)
         row_d = '0;
      else if (line_end)
         row_d = (row_q == CMAX) ? row_q : row_q + ONE;

      frame_done_d = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);

      // a fresh error outranks a simultaneous clear
      line_err_d  = (line_end & (col_q != HD)) | (line_err_q & ~err_clr_i);
      // checked on entry to DONE so the flag rises together with frame_done
      frame_err_d = (frame_done_d & (row_d != VD)) | (frame_err_q & ~err_clr_i);

      win_hit = accept & (col_q >= TWO) & (row_q >= TWO) & (col_q < HD) & (row_q < VD);
   end

   assign win_valid_o   = win_valid_q;
   assign win_col_o     = win_col_q;
   assign win_row_o     = win_row_q;
   assign frame_start_o = frame_start_q;
   assign frame_done_o  = frame_done_q;
   assign line_err_o    = line_err_q;
   assign frame_err_o   = frame_err_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_matrix3x3_ctrl.sv
// tb/tb_matrix3x3_ctrl.sv - self-checking bench for matrix3x3_ctrl
module tb_matrix3x3_ctrl;

   localparam int HD = 8;
   localparam int VD = 6;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vsync = 1'b0;
   logic          href = 1'b0;
   logic          clken = 1'b0;
   logic          err_clr = 1'b0;
   logic          win_valid;
   logic [CW-1:0] win_col;
   logic [CW-1:0] win_row;
   logic          frame_start;
   logic          frame_done;
   logic          line_err;
   logic          frame_err;
   logic          busy;

   matrix3x3_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD), .CW(CW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .per_frame_vsync_i (vsync),
      .per_frame_href_i  (href),
      .per_frame_clken_i (clken),
      .err_clr_i         (err_clr),
      .win_valid_o       (win_valid),
      .win_col_o         (win_col),
      .win_row_o         (win_row),
      .frame_start_o     (frame_start),
      .frame_done_o      (frame_done),
      .line_err_o        (line_err),
      .frame_err_o       (frame_err),
      .busy_o            (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: expected window events keyed by the cycle they must appear
   bit exp_v[int];
   int exp_r[int];
   int exp_c[int];
   bit ck_hist[int];

   int   fs_cnt, fd_cnt, win_cnt;
   logic le_at_done, fe_at_done;
   bit   mon_e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      mon_e = exp_v.exists(cyc);
      chk("win_valid", win_valid, mon_e);
      if (win_valid) begin
         win_cnt++;
         chk("win_clken", ck_hist.exists(cyc - 2), 1);
      end
      if (win_valid && mon_e) begin
         chk("win_row", win_row, exp_r[cyc]);
         chk("win_col", win_col, exp_c[cyc]);
      end
      if (frame_start) fs_cnt++;
      if (frame_done) begin
         fd_cnt++;
         le_at_done = line_err;
         fe_at_done = frame_err;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_frame();
      fs_cnt = 0;
      fd_cnt = 0;
      win_cnt = 0;
      le_at_done = 1'b0;
      fe_at_done = 1'b0;
   endtask

   task automatic clear_model();
      exp_v.delete();
      exp_r.delete();
      exp_c.delete();
   endtask

   task automatic reset_zero(input string tag);
      chk({tag, "_win_valid"}, win_valid, 0);
      chk({tag, "_win_col"}, win_col, 0);
      chk({tag, "_win_row"}, win_row, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_line_err"}, line_err, 0);
      chk({tag, "_frame_err"}, frame_err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // One frame: nlines lines of HD pixels (bad_line carries HD-1), clken duty in percent.
   // stop_line >= 0 abandons the frame mid-line with href still high.
   task automatic send_frame(input int nlines, input int bad_line, input int duty,
                             input bit accepted, input int stop_line);
      int px;
      int len;
      int stall;
      vsync = 1'b1;
      repeat (2 + $urandom_range(2)) step();
      chk("busy_in_frame", busy, accepted);
      for (int l = 0; l < nlines; l++) begin
         len = (l == bad_line) ? HD - 1 : HD;
         px = 0;
         stall = 0;
         href = 1'b1;
         while (px < len) begin
            if (l == stop_line && px == 3) return;
            clken = (duty >= 100) || ($urandom_range(99) < duty) || (stall >= 3);
            if (clken) begin
               ck_hist[cyc] = 1'b1;
               if (accepted && l >= 2 && px >= 2 && l < VD && px < HD) begin
                  exp_v[cyc + 2] = 1'b1;
                  exp_r[cyc + 2] = l - 1;
                  exp_c[cyc + 2] = px - 1;
               end
               px++;
               stall = 0;
            end else begin
               stall++;
            end
            step();
         end
         href = 1'b0;
         clken = 1'b0;
         repeat (2 + $urandom_range(1)) step();
      end
      vsync = 1'b0;
      repeat (4) step();
   endtask

   task automatic check_frame(input string tag, input int e_fs, input int e_fd, input int e_win,
                              input int e_le, input int e_fe);
      chk({tag, "_frame_start_cnt"}, fs_cnt, e_fs);
      chk({tag, "_frame_done_cnt"}, fd_cnt, e_fd);
      chk({tag, "_win_cnt"}, win_cnt, e_win);
      chk({tag, "_line_err_at_done"}, le_at_done, e_le);
      chk({tag, "_frame_err_at_done"}, fe_at_done, e_fe);
      chk({tag, "_busy_after"}, busy, 0);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      clear_frame();
      repeat (3) @(posedge clk);
      #1;
      reset_zero("reset");
      rst_n = 1'b1;
      step();
      step();

      // clean frame, clken every cycle
      clear_frame();
      send_frame(VD, -1, 100, 1'b1, -1);
      check_frame("clean", 1, 1, 24, 0, 0);

      // 50% clken duty inside href
      clear_frame();
      send_frame(VD, -1, 50, 1'b1, -1);
      check_frame("duty50", 1, 1, 24, 0, 0);

      // line 3 short by one pixel: one window fewer, line_err sticky until cleared
      clear_frame();
      send_frame(VD, 3, 100, 1'b1, -1);
      check_frame("short_line", 1, 1, 23, 1, 0);
      @(negedge clk);
      chk("line_err_held", line_err, 1);
      pulse_clr();
      chk("line_err_cleared", line_err, 0);

      // frame with one line missing
      clear_frame();
      send_frame(VD - 1, -1, 70, 1'b1, -1);
      check_frame("short_frame", 1, 1, 18, 0, 1);
      pulse_clr();
      chk("frame_err_cleared", frame_err, 0);

      // vsync already high when reset releases: that frame is ignored
      rst_n = 1'b0;
      clear_model();
      vsync = 1'b1;
      repeat (2) step();
      rst_n = 1'b1;
      clear_frame();
      repeat (3) step();
      chk("vsync_high_busy", busy, 0);
      send_frame(VD, -1, 100, 1'b0, -1);
      check_frame("partial_ignored", 0, 0, 0, 0, 0);
      clear_frame();
      send_frame(VD, -1, 100, 1'b1, -1);
      check_frame("after_partial", 1, 1, 24, 0, 0);

      // reset asserted in the middle of a line
      clear_frame();
      send_frame(VD, -1, 100, 1'b1, 3);
      rst_n = 1'b0;
      clear_model();
      #1;
      reset_zero("midline_reset");
      vsync = 1'b0;
      href = 1'b0;
      clken = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      clear_frame();
      send_frame(VD, -1, 100, 1'b1, -1);
      check_frame("after_reset", 1, 1, 24, 0, 0);

      // a few random-duty frames
      for (int f = 0; f < 3; f++) begin
         clear_frame();
         send_frame(VD, -1, 30 + $urandom_range(60), 1'b1, -1);
         check_frame("random", 1, 1, 24, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
